acc_cali_seq: RTL and testbench

Step scheduler for the accelerometer calibration pulse generator. It holds a small table of calibration steps, each a (low, high, periods) triple. On command it plays the steps in order: it configures the generator's low/high counts and mode, gates its laser-start enable, and counts completed pulses. Between steps it forces a gap so the generator's counters clear. It sits between the register/command interface and the pulse generator, and reports busy, done and progress status.

---
 rtl/acc_cali_pkg.sv | 33 +++
 rtl/acc_cali_seq_if.sv | 48 ++++
 rtl/acc_cali_step_ram.sv | 41 ++++
 rtl/acc_cali_seq.sv | 198 +++++++++++++++++++
 tb/tb_acc_cali_seq.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_cali_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acc_cali_pkg
// Purpose  : Shared types and constants for the accelerometer calibration
//            step scheduler (FSM states, step-table entry, gap floor).
// Revision : 1.0 - initial release
// ============================================================================
package acc_cali_pkg;

  // Smallest gap that still lets the generator's counters clear between steps
  localparam int c_min_gap = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [31:0] low;
    logic [31:0] high;
    logic [15:0] periods;
  } step_entry_t;

  // A zero-period entry still plays one pulse
  function automatic logic [15:0] eff_periods(input logic [15:0] p);
    return (p == 16'd0) ? 16'd1 : p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/acc_cali_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : acc_cali_seq_if
// Purpose  : Command/table-write side and generator side of the calibration
//            step scheduler bundled as one interface. The scheduler is the
//            slave; the register block / generator pair is the master.
// Revision : 1.0 - initial release
// ============================================================================
interface acc_cali_seq_if #(
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en_i;
  logic [AW-1:0] wr_addr_i;
  logic [31:0]   wr_low_i;
  logic [31:0]   wr_high_i;
  logic [15:0]   wr_periods_i;
  logic [AW:0]   step_num_i;
  logic          start_i;
  logic          abort_i;
  logic          acc_cali_ctrl_i;
  logic          laser_start_o;
  logic          acc_cali_mode_o;
  logic [31:0]   acc_cali_low_o;
  logic [31:0]   acc_cali_high_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [AW-1:0] step_idx_o;
  logic [15:0]   period_cnt_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_low_i, wr_high_i, wr_periods_i,
    output step_num_i, start_i, abort_i, acc_cali_ctrl_i,
    input  laser_start_o, acc_cali_mode_o, acc_cali_low_o, acc_cali_high_o,
    input  busy_o, done_o, err_o, step_idx_o, period_cnt_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_low_i, wr_high_i, wr_periods_i,
    input  step_num_i, start_i, abort_i, acc_cali_ctrl_i,
    output laser_start_o, acc_cali_mode_o, acc_cali_low_o, acc_cali_high_o,
    output busy_o, done_o, err_o, step_idx_o, period_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/acc_cali_step_ram.sv
`default_nettype none
// ============================================================================
// Module   : acc_cali_step_ram
// Purpose  : DEPTH x 80-bit step table. Synchronous write, registered read.
//            A write to the address being read in the same cycle is forwarded
//            so a write+start pair plays the freshly written entry.
// Revision : 1.0 - initial release
// ============================================================================
module acc_cali_step_ram
  import acc_cali_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  step_entry_t   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output step_entry_t   rdata_o
);

  step_entry_t r_mem [DEPTH];
  step_entry_t r_rdata;

  // Table write and registered read with write-first forwarding
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
    if (we_i && (waddr_i == raddr_i)) begin
      r_rdata <= wdata_i;
    end else begin
      r_rdata <= r_mem[raddr_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule
`default_nettype wire

// File: rtl/acc_cali_seq.sv
`default_nettype none
// ============================================================================
// Module   : acc_cali_seq
// Purpose  : Step scheduler for the accelerometer calibration pulse generator.
//            Plays (low, high, periods) steps from a table, gating the
//            generator enable, counting completed pulses and forcing a gap
//            between steps so the generator counters clear.
// Options  : ACC_CALI_SEQ_LOOP_EN - replay the table until abort instead of
//            stopping after a single pass.
// Revision : 1.0 - initial release
// ============================================================================
module acc_cali_seq
  import acc_cali_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  acc_cali_seq_if.slave bus
);

  localparam int AW        = $clog2(DEPTH);
  localparam int c_gap_len = (GAP_CYCLES < c_min_gap) ? c_min_gap : GAP_CYCLES;
  localparam int c_gap_w   = $clog2(c_gap_len);
  localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'(c_gap_len - 1);
  localparam logic [AW-1:0]      c_idx_one  = AW'(1);
  localparam logic [AW:0]        c_depth_n  = (AW+1)'(DEPTH);

  seq_state_t         r_state;
  logic [AW:0]        r_step_cnt;
  logic [AW-1:0]      r_step_idx;
  logic [15:0]        r_target;
  logic [15:0]        r_period_cnt;
  logic [c_gap_w-1:0] r_gap_cnt;
  logic [1:0]         r_ctrl_q;
  logic               r_laser;
  logic               r_mode;
  logic [31:0]        r_low;
  logic [31:0]        r_high;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic               w_fall;
  logic               w_num_ok;
  logic               w_wr_ok;
  logic               w_last;
  logic [AW:0]        w_idx_inc;
  logic [AW-1:0]      w_idx_next;
  logic [AW-1:0]      w_rd_addr;
  step_entry_t        w_wr_entry;
  step_entry_t        w_rd_entry;

  assign w_fall     = r_ctrl_q[1] & ~r_ctrl_q[0];
  assign w_num_ok   = (bus.step_num_i != '0) && (bus.step_num_i <= c_depth_n);
  assign w_wr_ok    = bus.wr_en_i && (r_state == ST_IDLE);
  assign w_idx_inc  = {1'b0, r_step_idx} + {{AW{1'b0}}, 1'b1};
  assign w_idx_next = r_step_idx + c_idx_one;
  assign w_last     = (w_idx_inc == r_step_cnt);
  assign w_wr_entry = '{low: bus.wr_low_i, high: bus.wr_high_i, periods: bus.wr_periods_i};

  // Read address looks one step ahead so the entry is ready in LOAD
  always_comb begin
    w_rd_addr = r_step_idx;
    if (r_state == ST_IDLE) begin
      w_rd_addr = '0;
    end else if ((r_state == ST_GAP) && (r_gap_cnt == '0)) begin
`ifdef ACC_CALI_SEQ_LOOP_EN
      w_rd_addr = w_last ? '0 : w_idx_next;
`else
      w_rd_addr = w_idx_next;
`endif
    end
  end

  acc_cali_step_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_step_ram (
    .clk_i   (clk_i),
    .we_i    (w_wr_ok),
    .waddr_i (bus.wr_addr_i),
    .wdata_i (w_wr_entry),
    .raddr_i (w_rd_addr),
    .rdata_o (w_rd_entry)
  );

  // Sequencer FSM with registered outputs; abort overrides every transition
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_step_cnt   <= '0;
      r_step_idx   <= '0;
      r_target     <= '0;
      r_period_cnt <= '0;
      r_gap_cnt    <= '0;
      r_ctrl_q     <= '0;
      r_laser      <= 1'b0;
      r_mode       <= 1'b0;
      r_low        <= '0;
      r_high       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_ctrl_q <= {r_ctrl_q[0], bus.acc_cali_ctrl_i};
      r_done   <= 1'b0;
      r_err    <= (r_state != ST_IDLE) && bus.wr_en_i;

      if ((r_state != ST_IDLE) && bus.abort_i) begin
        r_state <= ST_IDLE;
        r_laser <= 1'b0;
        r_mode  <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start_i) begin
              if (w_num_ok) begin
                r_step_cnt <= bus.step_num_i;
                r_step_idx <= '0;
                r_busy     <= 1'b1;
                r_state    <= ST_LOAD;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          ST_LOAD: begin
            r_low        <= w_rd_entry.low;
            r_high       <= w_rd_entry.high;
            r_target     <= eff_periods(w_rd_entry.periods);
            r_period_cnt <= '0;
            r_laser      <= 1'b1;
            r_mode       <= 1'b1;
            r_state      <= ST_RUN;
          end
          ST_RUN: begin
            if (r_period_cnt == r_target) begin
              r_laser   <= 1'b0;
              r_gap_cnt <= c_gap_load;
              r_state   <= ST_GAP;
            end else if (w_fall) begin
              r_period_cnt <= r_period_cnt + 16'd1;
            end
          end
          ST_GAP: begin
            if (r_gap_cnt == '0) begin
`ifdef ACC_CALI_SEQ_LOOP_EN
              if (w_last) begin
                r_step_idx <= '0;
                r_done     <= 1'b1;
              end else begin
                r_step_idx <= w_idx_next;
              end
              r_state <= ST_LOAD;
`else
              r_step_idx <= w_idx_next;
              if (w_last) begin
                r_done  <= 1'b1;
                r_mode  <= 1'b0;
                r_state <= ST_DONE;
              end else begin
                r_state <= ST_LOAD;
              end
`endif
            end else begin
              r_gap_cnt <= r_gap_cnt - 1'b1;
            end
          end
          ST_DONE: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: begin
            r_laser <= 1'b0;
            r_mode  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.laser_start_o   = r_laser;
  assign bus.acc_cali_mode_o = r_mode;
  assign bus.acc_cali_low_o  = r_low;
  assign bus.acc_cali_high_o = r_high;
  assign bus.busy_o          = r_busy;
  assign bus.done_o          = r_done;
  assign bus.err_o           = r_err;
  assign bus.step_idx_o      = r_step_idx;
  assign bus.period_cnt_o    = r_period_cnt;

endmodule
`default_nettype wire

// File: tb/tb_acc_cali_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_cali_seq
// Purpose  : Self-checking bench for acc_cali_seq. A behavioural pulse
//            generator answers laser_start_o; expected steps are queued at
//            start and compared as each step runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_cali_seq;

  localparam int DEPTH = 8;
  localparam int G     = 4;

  typedef struct packed {
    logic [31:0] low;
    logic [31:0] high;
    logic [15:0] tgt;
    logic [2:0]  idx;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;
  bit   aborting = 1'b0;
  exp_t q_exp[$];
  logic [31:0] m_low  [DEPTH];
  logic [31:0] m_high [DEPTH];
  logic [15:0] m_per  [DEPTH];

  acc_cali_seq_if #(.DEPTH(DEPTH)) bus ();

  acc_cali_seq #(.DEPTH(DEPTH), .GAP_CYCLES(G)) u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural generator: low phase then high phase while enabled
  task automatic gen();
    int cnt = 0;
    forever begin
      @(posedge clk_i); #1;
      if (!bus.laser_start_o) begin
        bus.acc_cali_ctrl_i = 1'b0;
        cnt = 0;
      end else if (bus.acc_cali_ctrl_i) begin
        if (cnt + 1 >= int'(bus.acc_cali_high_o)) begin bus.acc_cali_ctrl_i = 1'b0; cnt = 0; end
        else cnt++;
      end else begin
        if (cnt + 1 >= int'(bus.acc_cali_low_o)) begin bus.acc_cali_ctrl_i = 1'b1; cnt = 0; end
        else cnt++;
      end
    end
  endtask

  // Scoreboard monitor: pops an expected step on each laser rise
  task automatic monitor();
    logic prev_laser = 1'b0;
    int   low_cnt = 0;
    bit   gap_armed = 1'b0;
    bit   want_idle = 1'b0;
    exp_t cur = '0;
    forever begin
      @(negedge clk_i);
      if (want_idle) begin
        check_eq("idle_after_done_busy", bus.busy_o, 1'b0);
        check_eq("idle_after_done_mode", bus.acc_cali_mode_o, 1'b0);
        want_idle = 1'b0;
      end
      if (!bus.busy_o) gap_armed = 1'b0;
      if (bus.laser_start_o && !prev_laser) begin
        if (gap_armed) check_eq("gap_len", low_cnt, G + 1);
        check_eq("sb_nonempty", q_exp.size() != 0, 1'b1);
        if (q_exp.size() != 0) cur = q_exp.pop_front();
        check_eq("run_low", bus.acc_cali_low_o, cur.low);
        check_eq("run_high", bus.acc_cali_high_o, cur.high);
        check_eq("run_idx", bus.step_idx_o, cur.idx);
        check_eq("run_mode", bus.acc_cali_mode_o, 1'b1);
      end
      if (!bus.laser_start_o && prev_laser && !aborting) begin
        check_eq("period_cnt", bus.period_cnt_o, cur.tgt);
        check_eq("low_stable", bus.acc_cali_low_o, cur.low);
        check_eq("high_stable", bus.acc_cali_high_o, cur.high);
        check_eq("gap_mode", bus.acc_cali_mode_o, 1'b1);
        gap_armed = 1'b1;
      end
      if (!bus.laser_start_o) low_cnt = prev_laser ? 1 : low_cnt + 1;
      if (bus.done_o) begin
        n_done++;
        check_eq("done_busy", bus.busy_o, 1'b1);
        check_eq("done_timing", low_cnt, G + 1);
`ifndef ACC_CALI_SEQ_LOOP_EN
        want_idle = 1'b1;
`endif
      end
      prev_laser = bus.laser_start_o;
    end
  endtask

  task automatic wr_entry(input int a, input logic [31:0] lo, input logic [31:0] hi, input logic [15:0] pe);
    @(negedge clk_i);
    bus.wr_en_i = 1'b1; bus.wr_addr_i = 3'(a);
    bus.wr_low_i = lo; bus.wr_high_i = hi; bus.wr_periods_i = pe;
    @(negedge clk_i);
    bus.wr_en_i = 1'b0;
    m_low[a] = lo; m_high[a] = hi; m_per[a] = pe;
  endtask

  task automatic push_steps(input int n);
    for (int i = 0; i < n; i++)
      q_exp.push_back('{low: m_low[i], high: m_high[i],
                        tgt: (m_per[i] == 16'd0) ? 16'd1 : m_per[i], idx: 3'(i)});
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (!bus.busy_o) break;
    end
    check_eq("busy_drop", bus.busy_o, 1'b0);
  endtask

  // Full single-pass run, optionally with a table write in the start cycle
  task automatic run_seq(input int n, input bit wr_too, input logic [31:0] lo,
                         input logic [31:0] hi, input logic [15:0] pe);
    int done0;
    if (wr_too) begin m_low[0] = lo; m_high[0] = hi; m_per[0] = pe; end
    push_steps(n);
    done0 = n_done;
    @(negedge clk_i);
    bus.start_i = 1'b1; bus.step_num_i = 4'(n);
    if (wr_too) begin
      bus.wr_en_i = 1'b1; bus.wr_addr_i = 3'd0;
      bus.wr_low_i = lo; bus.wr_high_i = hi; bus.wr_periods_i = pe;
    end
    @(negedge clk_i);
    bus.start_i = 1'b0; bus.wr_en_i = 1'b0;
    check_eq("lat_load_laser", bus.laser_start_o, 1'b0);
    check_eq("lat_load_busy", bus.busy_o, 1'b1);
    check_eq("start_no_err", bus.err_o, 1'b0);
    @(negedge clk_i);
    check_eq("lat_run_laser", bus.laser_start_o, 1'b1);
    wait_idle(3000);
    check_eq("done_count", n_done - done0, 1);
    check_eq("sb_empty", q_exp.size(), 0);
  endtask

  task automatic wait_run(input int idx, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (bus.laser_start_o && (int'(bus.step_idx_o) == idx)) break;
    end
    check_eq("run_reached", bus.laser_start_o, 1'b1);
  endtask

  task automatic do_abort();
    aborting = 1'b1;
    bus.abort_i = 1'b1;
    @(negedge clk_i);
    check_eq("abort_laser", bus.laser_start_o, 1'b0);
    check_eq("abort_mode", bus.acc_cali_mode_o, 1'b0);
    check_eq("abort_busy", bus.busy_o, 1'b0);
    bus.abort_i = 1'b0;
    q_exp.delete();
    repeat (3) @(negedge clk_i);
    aborting = 1'b0;
  endtask

  initial begin
    int done0;
    bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_low_i = '0; bus.wr_high_i = '0;
    bus.wr_periods_i = '0; bus.step_num_i = '0; bus.start_i = 1'b0;
    bus.abort_i = 1'b0; bus.acc_cali_ctrl_i = 1'b0;
    fork
      gen();
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(negedge clk_i);
    check_eq("rst_laser", bus.laser_start_o, 1'b0);
    check_eq("rst_mode", bus.acc_cali_mode_o, 1'b0);
    check_eq("rst_lowhigh", {bus.acc_cali_low_o, bus.acc_cali_high_o}, 64'd0);
    check_eq("rst_flags", {bus.busy_o, bus.done_o, bus.err_o}, 3'b000);
    check_eq("rst_cnts", {bus.step_idx_o, bus.period_cnt_o}, 19'd0);
    rst_i = 1'b0;

`ifdef ACC_CALI_SEQ_LOOP_EN
    wr_entry(0, 32'd2, 32'd2, 16'd1);
    wr_entry(1, 32'd3, 32'd1, 16'd2);
    push_steps(2); push_steps(2); push_steps(1);
    @(negedge clk_i);
    bus.start_i = 1'b1; bus.step_num_i = 4'd2;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk_i);
        if (bus.done_o) break;
      end
      check_eq("loop_done_seen", bus.done_o, 1'b1);
      check_eq("loop_idx_wrap", bus.step_idx_o, 3'd0);
      check_eq("loop_busy", bus.busy_o, 1'b1);
    end
    @(negedge clk_i);
    check_eq("loop_rerun", bus.laser_start_o, 1'b1);
    do_abort();
    check_eq("loop_done_total", n_done, 2);
`else
    // Single step
    wr_entry(0, 32'd5, 32'd3, 16'd4);
    run_seq(1, 1'b0, '0, '0, '0);

    // Three steps
    wr_entry(0, 32'd2, 32'd2, 16'd1);
    wr_entry(1, 32'd4, 32'd1, 16'd2);
    wr_entry(2, 32'd1, 32'd6, 16'd3);
    run_seq(3, 1'b0, '0, '0, '0);

    // Abort mid-RUN of the second step
    done0 = n_done;
    push_steps(3);
    @(negedge clk_i);
    bus.start_i = 1'b1; bus.step_num_i = 4'd3;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    wait_run(1, 500);
    do_abort();
    check_eq("abort_no_done", n_done - done0, 0);

    // Rejected starts
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      bus.start_i = 1'b1; bus.step_num_i = (k == 0) ? 4'd0 : 4'd9;
      @(negedge clk_i);
      bus.start_i = 1'b0;
      check_eq("bad_start_err", bus.err_o, 1'b1);
      check_eq("bad_start_busy", bus.busy_o, 1'b0);
      @(negedge clk_i);
      check_eq("err_one_cycle", bus.err_o, 1'b0);
    end

    // Write and a second start while busy
    push_steps(1);
    @(negedge clk_i);
    bus.start_i = 1'b1; bus.step_num_i = 4'd1;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    wait_run(0, 50);
    bus.wr_en_i = 1'b1; bus.wr_addr_i = 3'd0;
    bus.wr_low_i = 32'd9; bus.wr_high_i = 32'd9; bus.wr_periods_i = 16'd9;
    @(negedge clk_i);
    bus.wr_en_i = 1'b0;
    check_eq("busy_wr_err", bus.err_o, 1'b1);
    bus.start_i = 1'b1; bus.step_num_i = 4'd2;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    @(negedge clk_i);
    check_eq("busy_start_no_err", bus.err_o, 1'b0);
    wait_idle(3000);
    run_seq(1, 1'b0, '0, '0, '0);

    // Zero periods plays one pulse
    wr_entry(0, 32'd3, 32'd2, 16'd0);
    run_seq(1, 1'b0, '0, '0, '0);

    // Write landing in the start cycle is used
    run_seq(1, 1'b1, 32'd6, 32'd2, 16'd2);
`endif

    repeat (4) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
